hex_syscall_io: RTL and testbench
=================================

HEX_SYSCALL_IO -- requirements
Module: hex_syscall_io

Interface
REQ-001 Parameter TX_DEPTH, default 4: TX FIFO entries, power of two, 2..16.
REQ-002 Parameter CODE_W, default 32: width of syscall code and argument.
REQ-003 i_clk  input  1  clock; all state rises on posedge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_svc_valid  input  1  processor is executing SVC; held until o_svc_done.
REQ-006 i_svc_code  input  CODE_W  syscall number (processor areg): 0=EXIT, 1=WRITE, 2=READ.
REQ-007 i_svc_arg  input  CODE_W  argument (processor breg); bits [7:0] are the byte or exit code.
REQ-008 o_svc_done  output  1  one-cycle completion pulse; processor advances PC on it.
REQ-009 o_svc_result  output  CODE_W  READ result, valid only with o_svc_done.
REQ-010 o_stall  output  1  = i_svc_valid & ~o_svc_done; holds processor state.
REQ-011 o_tx_valid / i_tx_ready / o_tx_data[7:0]  output/input/output  byte output stream, valid-ready.
REQ-012 i_rx_valid / o_rx_ready / i_rx_data[7:0]  input/output/input  byte input stream, valid-ready.
REQ-013 o_exit  output  1  sticky; simulation/system halt request.
REQ-014 o_exit_code  output  8  latched i_svc_arg[7:0] from EXIT.
REQ-015 o_err  output  1  one-cycle pulse on unknown syscall code.

Function
REQ-016 The FSM SHALL have states IDLE, WRITE, READ, DRAIN, HALT.
REQ-017 IDLE with i_svc_valid SHALL latch code and arg, then next state WRITE (code 1), READ (code 2), DRAIN (code 0); other codes: stay IDLE, assert o_svc_done and o_err in the following cycle, result 0.
REQ-018 WRITE SHALL push arg[7:0] into the TX FIFO and assert o_svc_done in the same cycle when the FIFO is not full, then return to IDLE; while full it SHALL remain in WRITE with o_svc_done=0.
REQ-019 A full FIFO SHALL NOT accept a push in a cycle where a pop occurs (no pass-through); the push occurs the next cycle.
REQ-020 READ SHALL drive o_rx_ready=1; on i_rx_valid it SHALL assert o_svc_done with o_svc_result={24'b0,i_rx_data} and return to IDLE; o_rx_ready=0 in all other states.
REQ-021 DRAIN SHALL wait until the TX FIFO is empty, then go to HALT; o_svc_done is never asserted for EXIT.
REQ-022 HALT SHALL be terminal until reset: o_exit=1, o_exit_code held, i_svc_valid ignored, o_stall follows REQ-010.
REQ-023 Minimum latency: WRITE, READ, unknown code = 2 cycles from i_svc_valid rising to o_svc_done.
REQ-024 After o_svc_done, IDLE SHALL accept a new request in the immediately following cycle (back-to-back SVCs).
REQ-025 TX FIFO: o_tx_valid = (count != 0); o_tx_data = head entry; pop on o_tx_valid & i_tx_ready; byte order preserved; pointers wrap modulo TX_DEPTH; count range 0..TX_DEPTH.
REQ-026 The FIFO SHALL continue draining in every state, including READ and HALT.
REQ-027 o_svc_done SHALL never assert in two consecutive cycles.

Reset
REQ-028 Reset SHALL force: state IDLE, FIFO count 0, pointers 0, o_svc_done=0, o_svc_result=0, o_tx_valid=0, o_rx_ready=0, o_exit=0, o_exit_code=0, o_err=0.
REQ-029 Reset mid-operation SHALL discard queued TX bytes and any in-flight request without emitting o_svc_done.
REQ-030 Outputs SHALL reach reset values asynchronously on i_rst rising, without a clock edge.

Verification
REQ-031 WRITE 0x41, i_tx_ready=1 -> o_svc_done at cycle 2; o_tx_data=0x41 with o_tx_valid at cycle 3.
REQ-032 i_tx_ready=0, five WRITEs 0x10..0x14 -> first four done, fifth stalls; raise i_tx_ready -> fifth done one cycle after first pop; output order 0x10..0x14.
REQ-033 READ with i_rx_valid low 10 cycles, then byte 0x7F -> o_svc_done same cycle as handshake, o_svc_result=0x0000007F.
REQ-034 Three WRITEs queued, then EXIT arg 0x03 -> o_exit rises only after third byte popped; o_exit_code=0x03; later SVC ignored.
REQ-035 Code 0x9 -> o_err and o_svc_done pulse together at cycle 2, result 0; assert i_rst during WRITE stall -> FIFO empty, no done.

Source files
------------

// File: rtl/hex_syscall_io.sv
`default_nettype none
// ============================================================================
// Module      : hex_syscall_io
// Description : Syscall (SVC) responder giving a processor EXIT/WRITE/READ
//               services over byte valid-ready streams, with a TX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_syscall_io #(
  parameter int TX_DEPTH = 4,
  parameter int CODE_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_svc_valid,
  input  logic [CODE_W-1:0] i_svc_code,
  input  logic [CODE_W-1:0] i_svc_arg,
  output logic              o_svc_done,
  output logic [CODE_W-1:0] o_svc_result,
  output logic              o_stall,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [7:0]        o_tx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  input  logic [7:0]        i_rx_data,
  output logic              o_exit,
  output logic [7:0]        o_exit_code,
  output logic              o_err
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CODE_W-1:0] c_svc_exit  = CODE_W'(0);
  localparam logic [CODE_W-1:0] c_svc_write = CODE_W'(1);
  localparam logic [CODE_W-1:0] c_svc_read  = CODE_W'(2);
  localparam logic [CNT_W-1:0]  c_cnt_full  = CNT_W'(TX_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_arg;
  logic [7:0]        r_exit_code;
  logic              r_err_pending;

  logic [7:0]        r_mem [TX_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_latch;
  logic              w_err_set;
  logic              w_done;
  logic              w_enter_halt;
  logic [CODE_W-1:0] w_result;

  // Only the low byte of the argument carries meaning for these services.
  logic              w_unused_arg_hi;
  assign w_unused_arg_hi = ^i_svc_arg[CODE_W-1:8];

  assign w_full  = (r_count == c_cnt_full);
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & i_tx_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_push       = 1'b0;
    w_done       = 1'b0;
    w_latch      = 1'b0;
    w_err_set    = 1'b0;
    w_enter_halt = 1'b0;
    w_result     = '0;
    o_rx_ready   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // The processor still holds the rejected request during the error
        // completion cycle, so it must not be latched a second time.
        if (i_svc_valid && !r_err_pending) begin
          w_latch = 1'b1;
          if (i_svc_code == c_svc_write) begin
            w_state_nxt = S_WRITE;
          end else if (i_svc_code == c_svc_read) begin
            w_state_nxt = S_READ;
          end else if (i_svc_code == c_svc_exit) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        o_rx_ready = 1'b1;
        if (i_rx_valid) begin
          w_done      = 1'b1;
          w_result    = CODE_W'(i_rx_data);
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_empty) begin
          w_enter_halt = 1'b1;
          w_state_nxt  = S_HALT;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_arg         <= '0;
      r_exit_code   <= '0;
      r_err_pending <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_err_pending <= w_err_set;
      if (w_latch) begin
        r_arg <= i_svc_arg[7:0];
      end
      if (w_enter_halt) begin
        r_exit_code <= r_arg;
      end
    end
  end

  // TX FIFO control; a full FIFO never pushes, so a simultaneous pop
  // simply frees the slot for the following cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_arg;
    end
  end

  assign o_svc_done   = w_done | r_err_pending;
  assign o_svc_result = w_result;
  assign o_stall      = i_svc_valid & ~o_svc_done;
  assign o_err        = r_err_pending;
  assign o_tx_valid   = ~w_empty;
  assign o_tx_data    = r_mem[r_rd_ptr];
  assign o_exit       = (r_state == S_HALT);
  assign o_exit_code  = r_exit_code;

endmodule
`default_nettype wire

// File: tb/tb_hex_syscall_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_syscall_io
// Description : Directed self-checking bench for hex_syscall_io.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_syscall_io;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_svc_valid = 1'b0;
  logic [31:0] i_svc_code = '0;
  logic [31:0] i_svc_arg = '0;
  logic        o_svc_done;
  logic [31:0] o_svc_result;
  logic        o_stall;
  logic        o_tx_valid;
  logic        i_tx_ready = 1'b0;
  logic [7:0]  o_tx_data;
  logic        i_rx_valid = 1'b0;
  logic        o_rx_ready;
  logic [7:0]  i_rx_data = '0;
  logic        o_exit;
  logic [7:0]  o_exit_code;
  logic        o_err;

  int n_checks = 0;
  int n_pass   = 0;

  hex_syscall_io #(.TX_DEPTH(4), .CODE_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_svc_valid(i_svc_valid), .i_svc_code(i_svc_code), .i_svc_arg(i_svc_arg),
    .o_svc_done(o_svc_done), .o_svc_result(o_svc_result), .o_stall(o_stall),
    .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_tx_data(o_tx_data),
    .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready), .i_rx_data(i_rx_data),
    .o_exit(o_exit), .o_exit_code(o_exit_code), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue a WRITE and hold it until completion, bounded to 20 cycles.
  task automatic do_write(input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    i_svc_valid = 1'b1; i_svc_code = 32'd1; i_svc_arg = {24'd0, b};
    for (int k = 0; k < 20 && !seen; k++) begin
      #1;
      if (o_svc_done) seen = 1'b1;
      tick();
    end
    i_svc_valid = 1'b0;
    check("do_write_done", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #1 i_rst = 1'b1;
    #1;
    check("rst_done",      {31'd0, o_svc_done}, 32'd0);
    check("rst_result",    o_svc_result, 32'd0);
    check("rst_misc",      {27'd0, o_tx_valid, o_rx_ready, o_exit, o_err, o_stall}, 32'd0);
    check("rst_exit_code", {24'd0, o_exit_code}, 32'd0);
    tick(); tick();
    i_rst = 1'b0;
    tick();

    // WRITE 0x41 with the sink ready
    i_tx_ready = 1'b1;
    i_svc_valid = 1'b1; i_svc_code = 32'd1; i_svc_arg = 32'h41;
    #1;
    check("w41_c1_done",  {31'd0, o_svc_done}, 32'd0);
    check("w41_c1_stall", {31'd0, o_stall}, 32'd1);
    tick(); #1;
    check("w41_c2_done",  {31'd0, o_svc_done}, 32'd1);
    check("w41_c2_stall", {31'd0, o_stall}, 32'd0);
    check("w41_c2_txv",   {31'd0, o_tx_valid}, 32'd0);
    tick(); i_svc_valid = 1'b0; #1;
    check("w41_c3_txv",   {31'd0, o_tx_valid}, 32'd1);
    check("w41_c3_data",  {24'd0, o_tx_data}, 32'h41);
    check("w41_c3_done",  {31'd0, o_svc_done}, 32'd0);
    tick(); #1;
    check("w41_c4_txv",   {31'd0, o_tx_valid}, 32'd0);

    // Five back-to-back WRITEs into a blocked sink
    tick();
    i_tx_ready = 1'b0;
    i_svc_valid = 1'b1; i_svc_code = 32'd1;
    for (int i = 0; i < 4; i++) begin
      i_svc_arg = 32'h10 + i;
      #1;
      check("bb_wait_done", {31'd0, o_svc_done}, 32'd0);
      tick(); #1;
      check("bb_done", {31'd0, o_svc_done}, 32'd1);
      tick();
    end
    i_svc_arg = 32'h14;
    #1;
    check("bb5_c1_done", {31'd0, o_svc_done}, 32'd0);
    tick(); #1;
    check("bb5_full_done",  {31'd0, o_svc_done}, 32'd0);
    check("bb5_full_stall", {31'd0, o_stall}, 32'd1);
    check("bb5_head",       {24'd0, o_tx_data}, 32'h10);
    tick();
    i_tx_ready = 1'b1;
    #1;
    check("bb5_pop_cycle_done", {31'd0, o_svc_done}, 32'd0);
    tick(); #1;
    check("bb5_after_pop_done", {31'd0, o_svc_done}, 32'd1);
    check("bb_order_11", {24'd0, o_tx_data}, 32'h11);
    tick(); i_svc_valid = 1'b0; #1;
    check("bb_done_gap", {31'd0, o_svc_done}, 32'd0);
    check("bb_order_12", {24'd0, o_tx_data}, 32'h12);
    tick(); #1;
    check("bb_order_13", {24'd0, o_tx_data}, 32'h13);
    tick(); #1;
    check("bb_order_14", {24'd0, o_tx_data}, 32'h14);
    check("bb_order_14v", {31'd0, o_tx_valid}, 32'd1);
    tick(); #1;
    check("bb_empty", {31'd0, o_tx_valid}, 32'd0);

    // READ with the source idle for 10 cycles, then 0x7F
    tick();
    i_svc_valid = 1'b1; i_svc_code = 32'd2; i_svc_arg = 32'd0;
    #1;
    check("rd_idle_rdy", {31'd0, o_rx_ready}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick(); #1;
      check("rd_wait", {30'd0, o_rx_ready, o_svc_done}, 32'd2);
    end
    tick();
    i_rx_valid = 1'b1; i_rx_data = 8'h7F;
    #1;
    check("rd_done",   {31'd0, o_svc_done}, 32'd1);
    check("rd_result", o_svc_result, 32'h0000007F);
    tick();
    i_svc_valid = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00;
    #1;
    check("rd_after", {30'd0, o_rx_ready, o_svc_done}, 32'd0);
    check("rd_after_result", o_svc_result, 32'd0);

    // Unknown code 9, immediately followed by a WRITE 0x5A
    tick();
    i_svc_valid = 1'b1; i_svc_code = 32'd9; i_svc_arg = 32'h55;
    #1;
    check("unk_c1", {30'd0, o_err, o_svc_done}, 32'd0);
    tick(); #1;
    check("unk_c2",       {30'd0, o_err, o_svc_done}, 32'd3);
    check("unk_c2_res",   o_svc_result, 32'd0);
    check("unk_c2_stall", {31'd0, o_stall}, 32'd0);
    tick();
    i_svc_code = 32'd1; i_svc_arg = 32'h5A;
    #1;
    check("unk_next_c1", {30'd0, o_err, o_svc_done}, 32'd0);
    tick(); #1;
    check("unk_next_c2", {30'd0, o_err, o_svc_done}, 32'd1);
    tick(); i_svc_valid = 1'b0; #1;
    check("unk_next_data", {23'd0, o_tx_valid, o_tx_data}, 32'h15A);
    tick();

    // Reset asserted during a WRITE stall
    i_tx_ready = 1'b0;
    do_write(8'h21); do_write(8'h22); do_write(8'h23); do_write(8'h24);
    i_svc_valid = 1'b1; i_svc_code = 32'd1; i_svc_arg = 32'h99;
    tick(); tick(); #1;
    check("rst_stall_done", {31'd0, o_svc_done}, 32'd0);
    check("rst_stall_txv",  {31'd0, o_tx_valid}, 32'd1);
    i_rst = 1'b1;
    #1;
    check("rst_mid_txv",  {31'd0, o_tx_valid}, 32'd0);
    check("rst_mid_done", {31'd0, o_svc_done}, 32'd0);
    tick(); #1;
    check("rst_hold_done", {31'd0, o_svc_done}, 32'd0);
    i_rst = 1'b0; i_svc_valid = 1'b0;
    tick(); #1;
    check("rst_post", {30'd0, o_tx_valid, o_svc_done}, 32'd0);

    // Three queued bytes, then EXIT 0x03
    do_write(8'hA1); do_write(8'hA2); do_write(8'hA3);
    i_svc_valid = 1'b1; i_svc_code = 32'd0; i_svc_arg = 32'h03;
    tick(); #1;
    check("ex_drain_exit",  {31'd0, o_exit}, 32'd0);
    check("ex_drain_stall", {31'd0, o_stall}, 32'd1);
    tick();
    i_tx_ready = 1'b1;
    #1;
    check("ex_pop_a1", {24'd0, o_tx_data}, 32'hA1);
    tick(); #1;
    check("ex_pop_a2", {23'd0, o_exit, o_tx_data}, 32'h0A2);
    tick(); #1;
    check("ex_pop_a3", {23'd0, o_exit, o_tx_data}, 32'h0A3);
    tick(); #1;
    check("ex_empty", {30'd0, o_exit, o_tx_valid}, 32'd0);
    tick(); #1;
    check("ex_exit",  {31'd0, o_exit}, 32'd1);
    check("ex_code",  {24'd0, o_exit_code}, 32'h03);
    check("ex_stall", {30'd0, o_stall, o_svc_done}, 32'd2);
    i_svc_code = 32'd1; i_svc_arg = 32'h77;
    tick(); tick(); #1;
    check("ex_ignored", {29'd0, o_exit, o_tx_valid, o_svc_done}, 32'd4);
    check("ex_code_held", {24'd0, o_exit_code}, 32'h03);
    i_rst = 1'b1;
    #1;
    check("ex_rst", {23'd0, o_exit, o_exit_code}, 32'd0);
    i_svc_valid = 1'b0;
    tick();
    i_rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
